alu_exec: RTL and testbench
===========================

# alu_exec

Execute stage of the 16-bit CPU datapath, directly downstream of the register-read stage. It consumes the registered operand pair (`rd_q`, `rs_q`) and the `en_out` strobe of the register group, and performs the ALU operation. It drives the register group's write port (`reg_en` one-hot, `d_in`) for write-back, and maintains a flags register. Single-cycle operations complete in one clock; MUL is a multi-cycle shift-add with a busy handshake.

## Interface
- `DW`, 16: datapath width; fixed at 16 in this CPU.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `en_in`  in  1: operands valid; connect to the register group's `en_out`.
- `alu_op`  in  4: operation code, aligned with `en_in`.
- `rd`  in  2: destination register index, aligned with `en_in`.
- `rd_q`  in  16: operand A (destination register value).
- `rs_q`  in  16: operand B (source register value).
- `en_out`  out  1: one-cycle pulse, instruction retired.
- `reg_en`  out  4: one-hot write enable to the register group; all zero when there is no write.
- `d_out`  out  16: write-back data; connect to the register group's `d_in`.
- `zf`, `nf`, `cf`  out  1 each: zero, negative and carry flags (registered).
- `busy`  out  1: high while MUL is in progress; upstream must hold `en_in` low while this is high.

## Operation
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~A
  - 0110 SHL: A<<1
  - 0111 SHR: A>>1, logical
  - 1000 MOV: B
  - 1001 CMP: A−B, flags only, no write
  - 1010 MUL: low 16 bits of A×B
  - 1011–1111 NOP
- Arithmetic is modulo 2^16. Width-extend to 17 bits for carry.
- Carry flag `cf` by opcode:
  - ADD: carry-out.
  - SUB/CMP: borrow (A<B unsigned).
  - SHL: bit shifted out of A[15].
  - SHR: bit shifted out of A[0].
  - MUL: high half of the 32-bit product is nonzero.
  - AND/OR/XOR/NOT/MOV: `cf` cleared.
- `zf` = (result==0). `nf` = result[15]. CMP updates flags from A−B.
- NOP: `en_out` pulses, `reg_en`=0, flags unchanged.
- Write-back: `reg_en` = one-hot of `rd` (bit `rd` set) for exactly the `en_out` cycle; `d_out` holds the result.
- FSM with two states:
  - IDLE: `en_in`=1 and op≠MUL → compute, register the outputs, stay in IDLE. `en_in`=1 and op=MUL → latch A, B and `rd`; clear the 32-bit accumulator; set count=0; go to MUL.
  - MUL: each cycle, if multiplier bit[count] is set, add (A<<count) into the accumulator; count++. After count=15 is processed → register the result, pulse `en_out`/`reg_en`, update flags, return to IDLE.
- `en_in` asserted while `busy`=1 is ignored: no retire, no state change. This is a protocol violation by upstream.
- `d_out` holds its last value between retirements. Flags hold between updates.

## Timing
- Reset: when `rst`=0 at an edge, then after that edge: `en_out`=0, `reg_en`=0, `d_out`=0, `zf`=`nf`=`cf`=0, `busy`=0, state=IDLE, counter=0. Reset during MUL aborts it with no write-back.
- Single-cycle op: `en_in` sampled at edge N → `en_out`/`reg_en`/`d_out`/flags valid after edge N (visible in cycle N+1). Back-to-back `en_in` every cycle is supported at full throughput.
- MUL: `en_in` sampled at edge N.
  - `busy`=1 from after edge N through cycle N+16.
  - Retire after edge N+16 (`en_out` high in cycle N+17); `busy`=0 in that same cycle.
  - A new `en_in` is accepted at edge N+17.
- `en_out` and `reg_en` are never high for more than one consecutive cycle per instruction.

## Configuration
- `ALU_MUL_EN` defined: MUL is implemented as above, including the MUL state, the counter and the 32-bit accumulator.
- `ALU_MUL_EN` undefined: no MUL hardware. Opcode 1010 behaves as NOP (single-cycle `en_out`, no write, flags unchanged). `busy` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 2 edges → all outputs 0. Release, idle 3 cycles → `en_out` stays 0.
- ADD wrap: A=0xFFFF, B=0x0001, `rd`=2 → next cycle `d_out`=0x0000, `reg_en`=0100, `zf`=1, `cf`=1, `nf`=0, `en_out` high for 1 cycle.
- SUB, then CMP back-to-back:
  - SUB: A=0x0003, B=0x0005, `rd`=1 → `d_out`=0xFFFE, `reg_en`=0010, `cf`=1, `nf`=1.
  - CMP: A=0x0007, B=0x0007 → `reg_en`=0000, `zf`=1, `cf`=0; `d_out` stays 0xFFFE.
- MUL (`ALU_MUL_EN` defined): A=0x0123, B=0x0100, `rd`=3 → `busy` high 16 cycles; `en_in` pulsed mid-run is ignored. Then `d_out`=0x2300, `cf`=1, `reg_en`=1000. Without the macro: `busy` never rises, `reg_en`=0.
- Reset mid-MUL: start MUL, pull `rst` low at cycle 5 → `busy`=0, no `en_out`, flags 0. A subsequent ADD completes normally.
- Shifts and NOP:
  - SHL: A=0x8001 → `d_out`=0x0002, `cf`=1.
  - SHR: A=0x0001 → `d_out`=0x0000, `zf`=1, `cf`=1.
  - NOP: opcode 1111 → `en_out` pulses, flags unchanged.

Source files
------------

// File: rtl/alu_exec.sv
// Execute stage of the 16-bit CPU: single-cycle ALU ops, write-back port and flags.
// Define ALU_MUL_EN to build the 16-cycle shift-add multiplier; otherwise opcode 1010 retires as a NOP.
module alu_exec #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [3:0]    alu_op,
  input  logic [1:0]    rd,
  input  logic [DW-1:0] rd_q,
  input  logic [DW-1:0] rs_q,
  output logic          en_out,
  output logic [3:0]    reg_en,
  output logic [DW-1:0] d_out,
  output logic          zf,
  output logic          nf,
  output logic          cf,
  output logic          busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  function automatic logic [2:0] flags_of(input logic [DW-1:0] res, input logic cy);
    return {(res == '0), res[DW-1], cy};
  endfunction

  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_cy;
  logic          w_alu_wr;
  logic          w_alu_upd;

  // Width-extended so the top bit is carry-out for ADD and borrow for SUB/CMP.
  assign w_sum  = {1'b0, rd_q} + {1'b0, rs_q};
  assign w_diff = {1'b0, rd_q} - {1'b0, rs_q};

  always_comb begin
    w_alu_res = '0;
    w_alu_cy  = 1'b0;
    w_alu_wr  = 1'b1;
    w_alu_upd = 1'b1;
    case (alu_op)
      OP_ADD: begin w_alu_res = w_sum[DW-1:0];  w_alu_cy = w_sum[DW];  end
      OP_SUB: begin w_alu_res = w_diff[DW-1:0]; w_alu_cy = w_diff[DW]; end
      OP_AND: w_alu_res = rd_q & rs_q;
      OP_OR:  w_alu_res = rd_q | rs_q;
      OP_XOR: w_alu_res = rd_q ^ rs_q;
      OP_NOT: w_alu_res = ~rd_q;
      OP_SHL: begin w_alu_res = {rd_q[DW-2:0], 1'b0}; w_alu_cy = rd_q[DW-1]; end
      OP_SHR: begin w_alu_res = {1'b0, rd_q[DW-1:1]}; w_alu_cy = rd_q[0];    end
      OP_MOV: w_alu_res = rs_q;
      OP_CMP: begin w_alu_res = w_diff[DW-1:0]; w_alu_cy = w_diff[DW]; w_alu_wr = 1'b0; end
      default: begin
        w_alu_wr  = 1'b0;
        w_alu_upd = 1'b0;
      end
    endcase
  end

  logic w_idle;
  logic w_mul_start;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(DW);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_mul_done;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [1:0]      r_mrd;
  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] w_addend;
  logic [2*DW-1:0] w_acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_mul_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_in && alu_op == OP_MUL) begin
          w_mul_start = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(DW - 1)) begin
          w_mul_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idle    = (r_state == S_IDLE);
  assign busy      = (r_state == S_MUL);
  assign w_addend  = r_b[r_cnt] ? ({{DW{1'b0}}, r_a} << r_cnt) : '0;
  assign w_acc_nxt = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_mul_start) begin
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Operand and accumulator registers carry data only; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (w_mul_start) begin
      r_a   <= rd_q;
      r_b   <= rs_q;
      r_mrd <= rd;
      r_acc <= '0;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
    end
  end
`else
  assign w_idle      = 1'b1;
  assign w_mul_start = 1'b0;
  assign busy        = 1'b0;
`endif

  logic          w_ret;
  logic          w_ret_wr;
  logic          w_ret_upd;
  logic [DW-1:0] w_ret_res;
  logic          w_ret_cy;
  logic [1:0]    w_ret_rd;

  always_comb begin
    w_ret     = 1'b0;
    w_ret_wr  = 1'b0;
    w_ret_upd = 1'b0;
    w_ret_res = w_alu_res;
    w_ret_cy  = w_alu_cy;
    w_ret_rd  = rd;
    if (en_in && w_idle && !w_mul_start) begin
      w_ret     = 1'b1;
      w_ret_wr  = w_alu_wr;
      w_ret_upd = w_alu_upd;
    end
`ifdef ALU_MUL_EN
    if (w_mul_done) begin
      w_ret     = 1'b1;
      w_ret_wr  = 1'b1;
      w_ret_upd = 1'b1;
      w_ret_res = w_acc_nxt[DW-1:0];
      w_ret_cy  = |w_acc_nxt[2*DW-1:DW];
      w_ret_rd  = r_mrd;
    end
`endif
  end

  logic          r_en_out;
  logic [3:0]    r_reg_en;
  logic [DW-1:0] r_d_out;
  logic [2:0]    r_flags;

  // Retire stage: en_out/reg_en are single-cycle pulses, d_out and flags hold until the next update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en_out <= 1'b0;
      r_reg_en <= 4'b0000;
      r_d_out  <= '0;
      r_flags  <= 3'b000;
    end else begin
      r_en_out <= w_ret;
      r_reg_en <= 4'b0000;
      if (w_ret && w_ret_wr) begin
        r_reg_en <= 4'b0001 << w_ret_rd;
        r_d_out  <= w_ret_res;
      end
      if (w_ret && w_ret_upd) r_flags <= flags_of(w_ret_res, w_ret_cy);
    end
  end

  assign en_out = r_en_out;
  assign reg_en = r_reg_en;
  assign d_out  = r_d_out;
  assign zf     = r_flags[2];
  assign nf     = r_flags[1];
  assign cf     = r_flags[0];

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed cases plus randomized ops against a plain-arithmetic model.
module tb_alu_exec;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0;
  logic [3:0]  alu_op = 4'b0;
  logic [1:0]  rd = 2'b0;
  logic [15:0] rd_q = 16'h0;
  logic [15:0] rs_q = 16'h0;
  logic        en_out;
  logic [3:0]  reg_en;
  logic [15:0] d_out;
  logic        zf, nf, cf, busy;

  alu_exec #(.DW(16)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .alu_op(alu_op), .rd(rd),
    .rd_q(rd_q), .rs_q(rs_q), .en_out(en_out), .reg_en(reg_en),
    .d_out(d_out), .zf(zf), .nf(nf), .cf(cf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          issue;
    int          due;
    bit          is_mul;
    logic [3:0]  reg_en;
    logic [15:0] d;
    logic        z, n, c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   done = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Architectural state as the model sees it after every issued instruction.
  logic [15:0] m_d = 16'h0;
  logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0;

  task automatic model_reset();
    m_d = 16'h0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
  endtask

  task automatic idle(input int n);
    en_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] r,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t    e;
    int      s;
    longint  p;
    bit      wr, upd, mul;
    logic [15:0] res;
    logic    cy;
    en_in = 1'b1; alu_op = op; rd = r; rd_q = a; rs_q = b;
    wr = 1'b1; upd = 1'b1; mul = 1'b0; cy = 1'b0; res = 16'h0;
    case (op)
      4'd0: begin s = int'(a) + int'(b); res = 16'(s); cy = (s > 65535); end
      4'd1: begin res = a - b; cy = (a < b); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: begin s = int'(a) * 2; res = 16'(s); cy = (s > 65535); end
      4'd7: begin res = a / 16'd2; cy = (a % 2 == 1); end
      4'd8: res = b;
      4'd9: begin res = a - b; cy = (a < b); wr = 1'b0; end
`ifdef ALU_MUL_EN
      4'd10: begin
        p = longint'(a) * longint'(b);
        res = 16'(p); cy = (p > 65535); mul = 1'b1;
      end
`endif
      default: begin wr = 1'b0; upd = 1'b0; end
    endcase
    if (wr) m_d = res;
    if (upd) begin m_z = (res == 16'h0); m_n = (res >= 16'h8000); m_c = cy; end
    e.issue  = cyc;
    e.due    = cyc + (mul ? 17 : 1);
    e.is_mul = mul;
    e.reg_en = wr ? (4'b0001 << r) : 4'b0000;
    e.d = m_d; e.z = m_z; e.n = m_n; e.c = m_c;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares everything visible on the output side once per cycle.
  initial begin : monitor
    exp_t        e;
    logic [15:0] l_d;
    logic        l_z, l_n, l_c;
    bit          exp_busy;
    l_d = 16'h0; l_z = 1'b0; l_n = 1'b0; l_c = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      if (rst_q !== 1'b1) begin
        chk("reset_outputs", {en_out, reg_en, d_out, zf, nf, cf, busy}, 64'd0);
        q.delete();
        l_d = 16'h0; l_z = 1'b0; l_n = 1'b0; l_c = 1'b0;
      end else begin
        exp_busy = (q.size() > 0) && q[0].is_mul && (cyc > q[0].issue) && (cyc < q[0].due);
        chk("busy", busy, exp_busy);
        if (en_out === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", en_out, 1'b0);
          end else begin
            e = q.pop_front();
            chk("retire_cycle", 64'(cyc), 64'(e.due));
            chk("retire_data", {reg_en, d_out, zf, nf, cf}, {e.reg_en, e.d, e.z, e.n, e.c});
            l_d = e.d; l_z = e.z; l_n = e.n; l_c = e.c;
          end
        end else begin
          chk("hold", {en_out, reg_en, d_out, zf, nf, cf}, {1'b0, 4'b0000, l_d, l_z, l_n, l_c});
          if (q.size() > 0) begin
            chk("retire_missing", (cyc >= q[0].due), 1'b0);
            if (cyc >= q[0].due) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [15:0] edges [4];
    logic [15:0] a, b;
    logic [3:0]  op;
    edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h8000; edges[3] = 16'h0001;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(3);

    issue(OP_ADD, 2'd2, 16'hFFFF, 16'h0001);
    idle(2);
    issue(OP_SUB, 2'd1, 16'h0003, 16'h0005);
    issue(OP_CMP, 2'd0, 16'h0007, 16'h0007);
    idle(2);

    issue(OP_MUL, 2'd3, 16'h0123, 16'h0100);
    idle(5);
`ifdef ALU_MUL_EN
    en_in = 1'b1; alu_op = OP_ADD; rd = 2'd0; rd_q = 16'h1111; rs_q = 16'h2222;
    @(negedge clk);
`else
    @(negedge clk);
`endif
    idle(10);
    idle(1);

    issue(OP_MUL, 2'd1, 16'hFFFF, 16'hFFFF);
    idle(3);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    model_reset();
    idle(1);
    issue(OP_ADD, 2'd0, 16'h1234, 16'h0001);
    idle(1);

    issue(OP_SHL, 2'd1, 16'h8001, 16'h0000);
    issue(OP_SHR, 2'd2, 16'h0001, 16'h0000);
    issue(OP_NOP, 2'd3, 16'hAAAA, 16'h5555);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      issue(op, 2'($urandom_range(0, 3)), a, b);
`ifdef ALU_MUL_EN
      if (op == OP_MUL) idle(16);
`endif
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    done = 1'b1;
  end

endmodule
